// File: rtl/reg_scoreboard_ctrl_if.sv
// Decode issue / writeback retire handshake bundle for the register scoreboard.
// master = decode + writeback side, slave = scoreboard.
interface reg_scoreboard_ctrl_if #(
  parameter int REGNO_BITS = 5
);
  logic                  issue_valid;
  logic                  issue_use_rs1;
  logic                  issue_use_rs2;
  logic [REGNO_BITS-1:0] issue_rs1;
  logic [REGNO_BITS-1:0] issue_rs2;
  logic                  issue_wr;
  logic [REGNO_BITS-1:0] issue_rd;
  logic                  issue_serialize;
  logic                  flush;
  logic                  retire_valid;
  logic [REGNO_BITS-1:0] retire_rd;
  logic                  issue_ok;
  logic                  stall;

  modport master (
    output issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1, issue_rs2,
           issue_wr, issue_rd, issue_serialize, flush, retire_valid, retire_rd,
    input  issue_ok, stall
  );

  modport slave (
    input  issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1, issue_rs2,
           issue_wr, issue_rd, issue_serialize, flush, retire_valid, retire_rd,
    output issue_ok, stall
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Issue/retire scheduler: per-register pending-write counters, in-flight count, drain FSM.
// Optional macro SCBD_RETIRE_BYPASS_EN lets a same-cycle retire clear a RAW hazard / finish drain.
module reg_scoreboard_ctrl #(
  parameter int REGNO_BITS   = 5,
  parameter int CNT_BITS     = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_BITS     = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  reg_scoreboard_ctrl_if.slave        sb,
  output logic [(1<<REGNO_BITS)-1:0]  busy_vec,
  output logic [INF_BITS-1:0]         inflight,
  output logic                        drain_active,
  output logic                        err_underflow
);

  localparam int                    NREG    = 1 << REGNO_BITS;
  localparam logic [CNT_BITS-1:0]   CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0]   CNT_ONE = CNT_BITS'(1);
  localparam logic [INF_BITS-1:0]   INF_MAX = INF_BITS'(MAX_INFLIGHT);
  localparam logic [INF_BITS-1:0]   INF_ONE = INF_BITS'(1);
  localparam logic [REGNO_BITS-1:0] R0      = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  cnt [NREG];
  logic [INF_BITS-1:0]  inflight_q;
  logic                 err_q;

  logic [CNT_BITS-1:0]  cnt_rs1, cnt_rs2, cnt_rd, cnt_ret;
  logic                 ret_act, ret_dec, ret_under;
  logic                 byp_rs1, byp_rs2, drain_done;
  logic                 haz_rs1, haz_rs2, hazard;
  logic                 wr_act, full, norm_ok;
  logic                 ok, fire, inc;
  logic [NREG-1:0]      inc_vec, dec_vec;

  assign cnt_rs1 = cnt[sb.issue_rs1];
  assign cnt_rs2 = cnt[sb.issue_rs2];
  assign cnt_rd  = cnt[sb.issue_rd];
  assign cnt_ret = cnt[sb.retire_rd];

  // A retire only decrements when something is outstanding; otherwise it is an underflow.
  assign ret_act   = sb.retire_valid & (sb.retire_rd != R0);
  assign ret_dec   = ret_act & (cnt_ret != '0);
  assign ret_under = ret_act & (cnt_ret == '0);

`ifdef SCBD_RETIRE_BYPASS_EN
  // Regfile writes on negedge, so the last outstanding write retiring now is visible to decode.
  assign byp_rs1    = ret_dec & (sb.retire_rd == sb.issue_rs1) & (cnt_rs1 == CNT_ONE);
  assign byp_rs2    = ret_dec & (sb.retire_rd == sb.issue_rs2) & (cnt_rs2 == CNT_ONE);
  assign drain_done = (inflight_q == '0) | ((inflight_q == INF_ONE) & ret_dec);
`else
  assign byp_rs1    = 1'b0;
  assign byp_rs2    = 1'b0;
  assign drain_done = (inflight_q == '0);
`endif

  assign haz_rs1 = sb.issue_use_rs1 & (sb.issue_rs1 != R0) & (cnt_rs1 != '0) & ~byp_rs1;
  assign haz_rs2 = sb.issue_use_rs2 & (sb.issue_rs2 != R0) & (cnt_rs2 != '0) & ~byp_rs2;
  assign hazard  = haz_rs1 | haz_rs2;

  // Full check deliberately ignores a same-cycle retire: it uses pre-update state only.
  assign wr_act  = sb.issue_wr & (sb.issue_rd != R0);
  assign full    = wr_act & ((cnt_rd == CNT_MAX) | (inflight_q == INF_MAX));
  assign norm_ok = ~sb.flush & ~hazard & ~full;

  always_comb begin
    state_nxt = state;
    ok        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sb.issue_valid & sb.issue_serialize & ~sb.flush) begin
          state_nxt = DRAIN;
        end else begin
          ok = norm_ok;
        end
      end
      DRAIN: begin
        if (sb.flush) begin
          state_nxt = IDLE;
        end else if (drain_done) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        ok = norm_ok;
        if (sb.flush | ~sb.issue_valid | norm_ok) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign fire    = sb.issue_valid & ok;
  assign inc     = fire & wr_act;
  assign inc_vec = inc     ? (NREG'(1) << sb.issue_rd)  : '0;
  assign dec_vec = ret_dec ? (NREG'(1) << sb.retire_rd) : '0;

  // Register 0 is never tracked; a matching inc and dec on one register cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] & ~dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] & ~inc_vec[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case ({inc, ret_dec})
        2'b10:   inflight_q <= inflight_q + INF_ONE;
        2'b01:   inflight_q <= inflight_q - INF_ONE;
        default: inflight_q <= inflight_q;
      endcase
      if (ret_under) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  assign sb.issue_ok   = ok;
  assign sb.stall      = sb.issue_valid & ~ok;
  assign inflight      = inflight_q;
  assign drain_active  = (state == DRAIN);
  assign err_underflow = err_q;

  a_inflight_bound: assert property (@(posedge clk) disable iff (!reset_n)
    inflight_q <= INF_MAX);
  a_no_issue_in_drain: assert property (@(posedge clk) disable iff (!reset_n)
    (state == DRAIN) |-> !ok);

endmodule
